// File: rtl/bus_target_pkg.sv
// Shared widths, FSM state encoding and latched request payload for bus_target.
package bus_target_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/bus_target_ram.sv
// Word storage for bus_target: one synchronous write port, one combinational read port.
module bus_target_ram
  import bus_target_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/bus_target.sv
// Memory-mapped bus target with handshake FSM and tri-state read data.
// Wait states are inserted only when BUS_TARGET_WAIT_EN is defined.
module bus_target
  import bus_target_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0100,
  parameter int unsigned       DEPTH       = 64,
  parameter int unsigned       WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] Data_Bus,
  input  logic [ADDR_W-1:0] Address_Bus,
  input  logic              Control,
  input  logic              IReady,
  output logic              TReady
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CMP_W = ADDR_W + 1;
`ifdef BUS_TARGET_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam int unsigned EFF_WAITS = WAIT_EN ? WAIT_CYCLES : 0;

  state_e            state_q, state_d;
  req_t              req_q, req_live_c, req_eff_c;
  logic [IDX_W-1:0]  idx_q, widx_c;
  logic [ADDR_W-1:0] offset_c;
  logic              hit_c;
  logic [DATA_W-1:0] rd_q, ram_rdata_c;
  logic              oe_q, oe_d, tready_d;
  logic              ram_we_c, load_rd_c, latch_c;

  // Address decode against the [BASE_ADDR, BASE_ADDR+DEPTH) window
  assign offset_c   = Address_Bus - BASE_ADDR;
  assign hit_c      = (Address_Bus >= BASE_ADDR) && ({1'b0, offset_c} < CMP_W'(DEPTH));
  assign req_live_c = '{write: Control, data: Data_Bus};

  // A zero-wait write commits on the same edge it is latched, so use live inputs in IDLE
  assign req_eff_c = (state_q == ST_IDLE) ? req_live_c : req_q;
  assign widx_c    = (state_q == ST_IDLE) ? offset_c[IDX_W-1:0] : idx_q;

`ifdef BUS_TARGET_WAIT_EN
  logic [CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                                         wait_cnt_q <= '0;
    else if (state_q == ST_WAIT && state_d == ST_WAIT) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    else                                             wait_cnt_q <= '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (IReady && hit_c) begin
          if (EFF_WAITS != 0) state_d = ST_WAIT;
          else if (Control)   state_d = ST_ACK;
          else                state_d = ST_DRIVE;
        end
      end
      ST_WAIT: begin
`ifdef BUS_TARGET_WAIT_EN
        if (!IReady) state_d = ST_IDLE;
        else if (wait_cnt_q == CNT_W'(EFF_WAITS - 1))
          state_d = req_q.write ? ST_ACK : ST_DRIVE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DRIVE: state_d = IReady ? ST_ACK : ST_IDLE;
      ST_ACK:   if (!IReady) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of registered outputs and datapath strobes, derived from the transition
  always_comb begin
    ram_we_c  = 1'b0;
    load_rd_c = 1'b0;
    latch_c   = 1'b0;
    tready_d  = 1'b0;
    oe_d      = 1'b0;
    if (state_q == ST_IDLE && state_d != ST_IDLE) latch_c = 1'b1;
    if (state_d == ST_ACK && state_q != ST_ACK && req_eff_c.write && !rst) ram_we_c = 1'b1;
    if (state_q == ST_DRIVE && state_d == ST_ACK) load_rd_c = 1'b1;
    if (state_q == ST_ACK && state_d == ST_ACK) tready_d = 1'b1;
    if (state_d == ST_ACK && !req_eff_c.write) oe_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= '0;
      idx_q  <= '0;
      rd_q   <= '0;
      oe_q   <= 1'b0;
      TReady <= 1'b0;
    end else begin
      if (latch_c) begin
        req_q <= req_live_c;
        idx_q <= offset_c[IDX_W-1:0];
      end
      if (load_rd_c) rd_q <= ram_rdata_c;
      oe_q   <= oe_d;
      TReady <= tready_d;
    end
  end

  assign Data_Bus = oe_q ? rd_q : {DATA_W{1'bz}};

  bus_target_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we_c),
    .waddr   (widx_c),
    .wdata   (req_eff_c.data),
    .raddr   (idx_q),
    .rdata_c (ram_rdata_c)
  );

endmodule

// File: tb/tb_bus_target.sv
// Self-checking bench for bus_target: directed scenarios plus randomized traffic vs a word-array model.
module tb_bus_target;

  localparam logic [15:0] BASE  = 16'h0100;
  localparam int unsigned DEPTH = 64;
`ifdef BUS_TARGET_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Address_Bus;
  logic        Control;
  logic        IReady;
  logic        TReady;
  wire  [31:0] Data_Bus;
  logic        tb_oe;
  logic [31:0] tb_data;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] model_mem [DEPTH];
  bit          known     [DEPTH];

  assign Data_Bus = tb_oe ? tb_data : 32'bz;

  always #5 clk = ~clk;

  bus_target #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .Data_Bus    (Data_Bus),
    .Address_Bus (Address_Bus),
    .Control     (Control),
    .IReady      (IReady),
    .TReady      (TReady)
  );

  function automatic bit is_hit(input logic [15:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + int'(DEPTH));
  endfunction

  // One initiator transaction; abort_at >= 0 drops IReady after edge k+abort_at (must be <= lat-2)
  task automatic txn(input logic [15:0] addr, input logic ctrl, input logic [31:0] wdata,
                     input int abort_at, input int hold, input bit scramble_in, input string tag);
    bit hit, aborted, rk, tr_exp, scramble;
    int idx, lat, drop_j, stop_j;
    logic [31:0] rexp;
    hit      = is_hit(addr);
    idx      = hit ? int'(addr) - int'(BASE) : 0;
    lat      = ctrl ? 1 + W : 2 + W;
    aborted  = hit && (abort_at >= 0);
    scramble = scramble_in && hit;
    rexp     = model_mem[idx];
    rk       = known[idx] && !ctrl;
    drop_j   = !hit ? 4 : (aborted ? abort_at : -1);
    stop_j   = (hit && !aborted) ? lat : drop_j + 3;

    @(negedge clk);
    Address_Bus = addr; Control = ctrl; IReady = 1'b1;
    tb_oe   = ctrl || !hit;
    tb_data = ctrl ? wdata : $urandom;
    @(posedge clk);
    for (int j = 0; j <= stop_j; j++) begin
      @(negedge clk);
      tr_exp = hit && !aborted && (j >= lat);
      vectors++;
      if (TReady !== tr_exp) begin
        errors++;
        $display("FAIL %s treddy j=%0d got %b exp %b", tag, j, TReady, tr_exp);
      end
      if (tb_oe) begin
        vectors++;
        if (Data_Bus !== tb_data) begin
          errors++;
          $display("FAIL %s bus_hiz j=%0d got %h exp %h", tag, j, Data_Bus, tb_data);
        end
      end else if (rk && hit && !aborted && j >= lat - 1) begin
        vectors++;
        if (Data_Bus !== rexp) begin
          errors++;
          $display("FAIL %s rdata j=%0d got %h exp %h", tag, j, Data_Bus, rexp);
        end
      end
      if (j == drop_j) begin
        IReady = 1'b0; tb_oe = 1'b1; tb_data = $urandom;
      end else if (scramble && IReady) begin
        Address_Bus = 16'($urandom);
        Control     = 1'($urandom);
        if (ctrl) tb_data = $urandom;
      end
    end

    if (hit && !aborted) begin
      if (ctrl) begin model_mem[idx] = wdata; known[idx] = 1'b1; end
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        vectors++;
        if (TReady !== 1'b1) begin
          errors++;
          $display("FAIL %s hold_treddy h=%0d got %b exp 1", tag, h, TReady);
        end
        if (rk && Data_Bus !== rexp) begin
          errors++;
          $display("FAIL %s hold_rdata h=%0d got %h exp %h", tag, h, Data_Bus, rexp);
        end
      end
      IReady = 1'b0; tb_oe = 1'b1; tb_data = $urandom;
      @(negedge clk);
      vectors++;
      if (TReady !== 1'b0 || Data_Bus !== tb_data) begin
        errors++;
        $display("FAIL %s release got tr=%b bus=%h exp tr=0 bus=%h", tag, TReady, Data_Bus, tb_data);
      end
    end
    IReady = 1'b0;
    tb_oe  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; IReady = 1'b1; Address_Bus = 16'h0105; Control = 1'b0;
    tb_oe = 1'b1; tb_data = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (TReady !== 1'b0 || Data_Bus !== tb_data) begin
        errors++;
        $display("FAIL reset got tr=%b bus=%h exp tr=0 bus=%h", TReady, Data_Bus, tb_data);
      end
    end
    rst = 1'b0; IReady = 1'b0; tb_oe = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    txn(16'h0105, 1'b1, 32'hDEADBEEF, -1, 0, 1'b0, "wr_0105");
    txn(16'h0105, 1'b0, 32'h0,        -1, 0, 1'b0, "rd_0105");
    txn(16'h0100, 1'b1, 32'h11112222, -1, 0, 1'b0, "wr_first");
    txn(16'h013F, 1'b1, 32'h3333CAFE, -1, 0, 1'b0, "wr_last");
    txn(16'h013F, 1'b0, 32'h0,        -1, 1, 1'b0, "rd_last");
    txn(16'h0100, 1'b0, 32'h0,        -1, 0, 1'b0, "rd_first");
  endtask

  task automatic test_miss();
    txn(16'h00FF, 1'b1, 32'hBAD0BAD0, -1, 0, 1'b0, "miss_wr_00ff");
    txn(16'h0140, 1'b1, 32'hBAD1BAD1, -1, 0, 1'b0, "miss_wr_0140");
    txn(16'h00FF, 1'b0, 32'h0,        -1, 0, 1'b0, "miss_rd_00ff");
    txn(16'h0140, 1'b0, 32'h0,        -1, 0, 1'b0, "miss_rd_0140");
    txn(16'h0100, 1'b0, 32'h0,        -1, 0, 1'b0, "miss_chk_first");
    txn(16'h013F, 1'b0, 32'h0,        -1, 0, 1'b0, "miss_chk_last");
  endtask

  task automatic test_abort();
    if (W > 0) begin
      txn(16'h0100, 1'b1, 32'h0BADF00D, 0,     0, 1'b0, "abort_wr_w0");
      txn(16'h0100, 1'b1, 32'h0BADF00E, W - 1, 0, 1'b0, "abort_wr_wl");
      txn(16'h0100, 1'b0, 32'h0,        -1,    0, 1'b0, "abort_chk");
    end
    txn(16'h0105, 1'b0, 32'h0, W,  0, 1'b0, "abort_rd_drive");
    txn(16'h0105, 1'b0, 32'h0, -1, 0, 1'b0, "abort_rd_after");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    Address_Bus = 16'h0105; Control = 1'b0; IReady = 1'b1; tb_oe = 1'b0;
    @(posedge clk);
    repeat (W + 1) @(negedge clk);
    rst = 1'b1; tb_oe = 1'b1; tb_data = $urandom;
    @(negedge clk);
    vectors++;
    if (TReady !== 1'b0 || Data_Bus !== tb_data) begin
      errors++;
      $display("FAIL reset_mid got tr=%b bus=%h exp tr=0 bus=%h", TReady, Data_Bus, tb_data);
    end
    rst = 1'b0; IReady = 1'b0; tb_oe = 1'b0;
    @(negedge clk);
    txn(16'h0105, 1'b0, 32'h0, -1, 0, 1'b0, "reset_mid_rd");
    vectors++;
    if (model_mem[5] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_mid_model got %h exp deadbeef", model_mem[5]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = BASE + 16'(i % 4);
      txn(a, 1'b1, $urandom, -1, i % 3, 1'b0, "b2b_wr");
      txn(a, 1'b0, 32'h0,    -1, (i + 1) % 3, 1'b0, "b2b_rd");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      logic [15:0] a;
      logic        c;
      int          ab, lat;
      a   = BASE - 16'd4 + 16'($urandom_range(0, DEPTH + 7));
      c   = 1'($urandom);
      lat = c ? 1 + W : 2 + W;
      ab  = -1;
      if (lat - 2 >= 0 && $urandom_range(0, 7) == 0) ab = $urandom_range(0, lat - 2);
      txn(a, c, $urandom, ab, $urandom_range(0, 2), 1'b1, "random");
    end
  endtask

  initial begin
    rst = 1'b1; IReady = 1'b0; Address_Bus = '0; Control = 1'b0;
    tb_oe = 1'b0; tb_data = '0;
    test_reset();
    test_directed();
    test_miss();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bus_target.md
BUS_TARGET -- requirements
Module: bus_target

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0100, first word address decoded by this target.
REQ-002 Parameter DEPTH, default 64, number of 32-bit words stored (power of two, 2..1024).
REQ-003 Parameter WAIT_CYCLES, default 2, wait states inserted before completion (0..15).
REQ-004 clk  input  1  single clock, all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-006 Data_Bus  inout  32  write data from initiator; read data driven by this block, high-Z otherwise.
REQ-007 Address_Bus  input  16  word address from initiator.
REQ-008 Control  input  1  1 = write, 0 = read.
REQ-009 IReady  input  1  initiator request valid; held until TReady seen, then dropped.
REQ-010 TReady  output  1  target completion acknowledge.

Function
REQ-011 Hit = Address_Bus in [BASE_ADDR, BASE_ADDR+DEPTH); word index = Address_Bus - BASE_ADDR.
REQ-012 FSM states IDLE, WAIT, DRIVE, ACK; only one transaction in flight.
REQ-013 IDLE: on edge with IReady=1 and hit, latch index, Control, Data_Bus; go WAIT if effective waits >0, else DRIVE (read) or ACK (write).
REQ-014 IDLE with IReady=1 and miss: no response, remain IDLE, never drive Data_Bus or TReady.
REQ-015 WAIT: count effective waits cycles, then go DRIVE (read) or ACK (write).
REQ-016 DRIVE (read only): load memory word into read register and drive it on Data_Bus; next edge go ACK.
REQ-017 Read data SHALL be stable on Data_Bus at least one full cycle before TReady rises, and held through ACK.
REQ-018 Write commit: latched data written to memory on the edge entering ACK, exactly once.
REQ-019 ACK: TReady=1 (registered); remain until IReady sampled 0, then IDLE with TReady=0 next cycle.
REQ-020 Latency, IReady first sampled at edge k: write TReady rises after edge k+1+W; read after edge k+2+W; W = effective waits.
REQ-021 Address_Bus/Control/Data_Bus changes after latch are ignored until IDLE.
REQ-022 IReady dropped while in WAIT or DRIVE: abort, IDLE next edge, no write commit, Data_Bus released.
REQ-023 Back-to-back: new request accepted only after IReady sampled 0 in ACK and block returned to IDLE.
REQ-024 Data_Bus driven only in DRIVE/ACK of a read; high-Z in all other states, including write ACK.

Reset
REQ-025 rst=1: state IDLE, TReady=0, Data_Bus high-Z, wait counter 0, latched fields 0.
REQ-026 Reset mid-transaction discards it; an uncommitted write is not committed.
REQ-027 Memory contents are not altered by reset.

Configuration
REQ-028 Macro BUS_TARGET_WAIT_EN defined: effective waits = WAIT_CYCLES.
REQ-029 Macro BUS_TARGET_WAIT_EN undefined: effective waits = 0, WAIT state unreachable, counter not built.

Structure
REQ-030 Package bus_target_pkg holds DATA_W=32, ADDR_W=16 and the FSM state enum.
REQ-031 Storage array in sub-module bus_target_ram (one synchronous write port, one read port); FSM and bus drivers in bus_target.

Verification
REQ-032 Write 0xDEADBEEF to 0x0105, WAIT_EN on, W=2 -> TReady rises after edge k+3, word 5 = 0xDEADBEEF, Data_Bus high-Z throughout.
REQ-033 Read 0x0105 after previous write -> Data_Bus=0xDEADBEEF one cycle before TReady, TReady after edge k+4; release after IReady=0.
REQ-034 Request to 0x00FF and 0x0140 -> TReady stays 0, Data_Bus high-Z, no memory change.
REQ-035 Write to 0x0100 with IReady dropped in WAIT -> IDLE, word 0 unchanged, TReady never rises.
REQ-036 rst pulsed during read DRIVE -> next cycle TReady=0, Data_Bus high-Z; following read of 0x0105 still returns 0xDEADBEEF.
REQ-037 Macro undefined, write then read 0x013F -> TReady after edge k+1 (write) and k+2 (read), data matches.
